// File: rtl/acc_sched_pkg.sv
// Shared types, default widths and the round-robin distance helper for the
// accumulator scheduler.
package acc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_OPW  = 4;
  localparam int unsigned DEF_ACCW = 8;
  localparam int unsigned DEF_LENW = 4;

  // Distance of idx after ptr going round a ring of n slots; ptr+1 is closest.
  function automatic int unsigned rr_dist(int unsigned idx, int unsigned ptr,
                                          int unsigned n);
    return (idx + 2 * n - ptr - 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: chooses the first requester after ptr_i,
// wrapping around, and returns it as one-hot plus index.
module rr_pick
  import acc_sched_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned best_dist;
  int unsigned best_idx;

  always_comb begin
    best_dist = N;
    best_idx  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && (rr_dist(i, 32'(ptr_i), N) < best_dist)) begin
        best_dist = rr_dist(i, 32'(ptr_i), N);
        best_idx  = i;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_o[i] = req_i[i] && (i == best_idx);
    end
  end

  assign idx_o = IW'(best_idx);
  assign any_o = |req_i;

endmodule

// File: rtl/acc_sched.sv
// Round-robin owner of a shared clear-able accumulator: clears it, forwards a
// declared number of operands from the granted requester, then reports the sum.
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned OPW  = DEF_OPW,
  parameter int unsigned ACCW = DEF_ACCW,
  parameter int unsigned LENW = DEF_LENW,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] req_len,
  input  logic [NREQ-1:0]      op_valid,
  input  logic [NREQ*OPW-1:0]  op_data,
  output logic [NREQ-1:0]      op_ready,
  output logic [NREQ-1:0]      gnt,
  output logic                 acc_clear,
  output logic [OPW-1:0]       acc_in,
  input  logic [ACCW-1:0]      acc_a,
  output logic                 res_valid,
  output logic [ACCW-1:0]      res_data,
  output logic [IW-1:0]        res_id
);

  // IDLE pick winner | CLR clear accumulator | RUN stream operands | DONE report
  state_e          state_q;
  logic [LENW-1:0] cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   ptr_q;

  logic [LENW-1:0] len_a [NREQ];
  logic [OPW-1:0]  op_a  [NREQ];
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            sel_valid;
  logic [OPW-1:0]  sel_data;
  logic            take;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign len_a[g] = req_len[g*LENW +: LENW];
    assign op_a[g]  = op_data[g*OPW +: OPW];
  end

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign sel_valid = op_valid[gidx_q];
  assign sel_data  = op_a[gidx_q];
  assign take      = rst_n && (state_q == ST_RUN) && sel_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= IW'(NREQ - 1);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_q   <= pick_gnt;
            gidx_q  <= pick_idx;
            cnt_q   <= len_a[pick_idx];
            state_q <= ST_CLR;
          end
        end
        ST_CLR: state_q <= (cnt_q == '0) ? ST_DONE : ST_RUN;
        ST_RUN: begin
          if (sel_valid) begin
            cnt_q <= cnt_q - LENW'(1);
            if (cnt_q == LENW'(1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptr_q   <= gidx_q;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Everything driving the accumulator or the result drops the moment reset is seen.
  assign gnt       = gnt_q;
  assign op_ready  = (rst_n && (state_q == ST_RUN)) ? gnt_q : '0;
  assign acc_in    = take ? sel_data : '0;
  assign acc_clear = !rst_n || (state_q == ST_CLR);
  assign res_valid = rst_n && (state_q == ST_DONE);
  assign res_data  = res_valid ? acc_a : '0;
  assign res_id    = res_valid ? gidx_q : '0;

endmodule

// File: tb/tb_acc_sched.sv
// Bench for acc_sched: transaction-level reference model checked every cycle,
// directed scenarios with literal results, then randomized traffic.
module tb_acc_sched;

  localparam int NREQ = 2;
  localparam int OPW  = 4;
  localparam int LENW = 4;
  localparam int IW   = 1;

  localparam int M_WAIT   = 0;
  localparam int M_CLEAR  = 1;
  localparam int M_STREAM = 2;
  localparam int M_REPORT = 3;

  typedef struct {
    int data;
    int data6;
    int id;
    int cyc;
  } res_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      op_valid;
  logic [NREQ*OPW-1:0]  op_data;

  logic [NREQ-1:0] op_ready, gnt;
  logic            acc_clear, res_valid;
  logic [OPW-1:0]  acc_in;
  logic [7:0]      acc8, res_data;
  logic [IW-1:0]   res_id;

  logic [NREQ-1:0] op_ready6, gnt6;
  logic            acc_clear6, res_valid6;
  logic [OPW-1:0]  acc_in6;
  logic [5:0]      acc6, res_data6;
  logic [IW-1:0]   res_id6;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_mode = 1'b0;
  int   stall_pct [NREQ];
  int   opq [NREQ][$];
  res_t act_log [$];
  res_t mdl_log [$];
  int   gnt_log [$];
  logic [NREQ-1:0] prev_gnt = '0;

  int m_owner = -1;
  int m_ptr   = NREQ - 1;
  int m_left  = 0;
  int m_sum   = 0;
  int m_stage = M_WAIT;

  acc_sched #(.NREQ(NREQ), .OPW(OPW), .ACCW(8), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready), .gnt(gnt),
    .acc_clear(acc_clear), .acc_in(acc_in), .acc_a(acc8),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id)
  );

  acc_sched #(.NREQ(NREQ), .OPW(OPW), .ACCW(6), .LENW(LENW)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready6), .gnt(gnt6),
    .acc_clear(acc_clear6), .acc_in(acc_in6), .acc_a(acc6),
    .res_valid(res_valid6), .res_data(res_data6), .res_id(res_id6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    acc8 <= acc_clear  ? 8'd0 : acc8 + 8'(acc_in);
    acc6 <= acc_clear6 ? 6'd0 : acc6 + 6'(acc_in6);
  end

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: advanced once per cycle at the falling edge.
  always @(negedge clk) begin
    int e_gnt, e_ready, e_in, e_clear, e_rv, e_rd, e_rd6, e_id, w;
    res_t r;
    e_gnt   = (m_owner >= 0) ? (1 << m_owner) : 0;
    e_ready = 0; e_in = 0; e_clear = 0; e_rv = 0; e_rd = 0; e_rd6 = 0; e_id = 0;
    w = 0;
    if (!rst_n) begin
      e_clear = 1;
      m_owner = -1;
      m_ptr   = NREQ - 1;
      m_stage = M_WAIT;
    end else begin
      case (m_stage)
        M_WAIT: begin
          if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
              w = (m_ptr + k) % NREQ;
              if (req[w]) break;
            end
            m_owner = w;
            m_left  = int'(req_len[w*LENW +: LENW]);
            m_sum   = 0;
            m_stage = M_CLEAR;
          end
        end
        M_CLEAR: begin
          e_clear = 1;
          m_stage = (m_left == 0) ? M_REPORT : M_STREAM;
        end
        M_STREAM: begin
          e_ready = 1 << m_owner;
          if (op_valid[m_owner]) begin
            e_in  = int'(op_data[m_owner*OPW +: OPW]);
            m_sum = m_sum + e_in;
            m_left--;
            if (m_left == 0) m_stage = M_REPORT;
          end
        end
        default: begin
          e_rv  = 1;
          e_rd  = m_sum % 256;
          e_rd6 = m_sum % 64;
          e_id  = m_owner;
          r.data = e_rd; r.data6 = e_rd6; r.id = e_id; r.cyc = cyc;
          mdl_log.push_back(r);
          m_ptr   = m_owner;
          m_owner = -1;
          m_stage = M_WAIT;
        end
      endcase
    end

    chk("gnt",       int'(gnt),       e_gnt);
    chk("op_ready",  int'(op_ready),  e_ready);
    chk("acc_in",    int'(acc_in),    e_in);
    chk("acc_clear", int'(acc_clear), e_clear);
    chk("res_valid", int'(res_valid), e_rv);
    chk("res_data",  int'(res_data),  e_rd);
    chk("res_id",    int'(res_id),    e_id);
    chk("w6_gnt",       int'(gnt6),       e_gnt);
    chk("w6_op_ready",  int'(op_ready6),  e_ready);
    chk("w6_res_valid", int'(res_valid6), e_rv);
    chk("w6_res_data",  int'(res_data6),  e_rd6);
    chk("w6_res_id",    int'(res_id6),    e_id);

    if (res_valid) begin
      r.data = int'(res_data); r.data6 = int'(res_data6);
      r.id = int'(res_id); r.cyc = cyc;
      act_log.push_back(r);
    end
    if (gnt != '0 && prev_gnt == '0) gnt_log.push_back(cyc);
    prev_gnt = gnt;
  end

  task automatic step();
    logic [NREQ-1:0] seen;
    int l;
    @(negedge clk);
    seen = gnt;
    for (int i = 0; i < NREQ; i++)
      if (op_valid[i] && op_ready[i] && opq[i].size() > 0) void'(opq[i].pop_front());
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (seen[i]) req[i] = 1'b0;
      if (rand_mode && !req[i] && !seen[i] && opq[i].size() == 0 &&
          $urandom_range(0, 99) < 30) begin
        l = int'($urandom_range(0, 15));
        req_len[i*LENW +: LENW] = LENW'(l);
        for (int k = 0; k < l; k++) opq[i].push_back(int'($urandom_range(0, 15)));
        req[i] = 1'b1;
      end else if (rand_mode && !req[i]) begin
        req_len[i*LENW +: LENW] = LENW'($urandom);
      end
      op_valid[i] = (opq[i].size() > 0) && ($urandom_range(0, 99) >= stall_pct[i]);
      op_data[i*OPW +: OPW] = op_valid[i] ? OPW'(opq[i][0]) : OPW'($urandom);
    end
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    req = '0;
    op_valid = '0;
    for (int i = 0; i < NREQ; i++) opq[i].delete();
    repeat (n) step();
    chk("rst_gnt",       int'(gnt),       0);
    chk("rst_acc_clear", int'(acc_clear), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_op_ready",  int'(op_ready),  0);
    chk("rst_acc_in",    int'(acc_in),    0);
    rst_n = 1'b1;
  endtask

  task automatic run_until(int n, int budget, string tag);
    int k;
    k = 0;
    while (act_log.size() < n && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_results_in_time"}, act_log.size(), n);
  endtask

  task automatic chk_res(string tag, int idx, int data, int data6, int id);
    chk({tag, "_present"}, int'(act_log.size() > idx), 1);
    if (act_log.size() > idx) begin
      chk({tag, "_data"},  act_log[idx].data,  data);
      chk({tag, "_data6"}, act_log[idx].data6, data6);
      chk({tag, "_id"},    act_log[idx].id,    id);
    end
    chk({tag, "_model_present"}, int'(mdl_log.size() > idx), 1);
    if (mdl_log.size() > idx) begin
      chk({tag, "_model_data"}, mdl_log[idx].data, data);
      chk({tag, "_model_id"},   mdl_log[idx].id,   id);
    end
  endtask

  task automatic clear_logs();
    act_log.delete();
    mdl_log.delete();
    gnt_log.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, k;
    rst_n = 1'b0; req = '0; req_len = '0; op_valid = '0; op_data = '0;
    for (int i = 0; i < NREQ; i++) stall_pct[i] = 0;
    do_reset(2);

    // A: single requester, three back-to-back operands
    clear_logs();
    opq[0] = '{5, 6, 7};
    req_len[0 +: LENW] = 4'd3;
    req[0] = 1'b1;
    t0 = cyc;
    run_until(1, 40, "A");
    chk_res("A", 0, 18, 18, 0);
    chk("A_gnt_cycle", (gnt_log.size() > 0) ? gnt_log[0] : -1, t0 + 1);
    chk("A_res_cycle", (act_log.size() > 0) ? act_log[0].cyc : -1, t0 + 5);

    // B: simultaneous requests after reset; r0 first, then r1, then r0 again
    do_reset(1);
    clear_logs();
    opq[0] = '{1, 2};
    opq[1] = '{3, 4};
    req_len = {4'd2, 4'd2};
    req = 2'b11;
    run_until(2, 60, "B1");
    chk_res("B_r0", 0, 3, 3, 0);
    chk_res("B_r1", 1, 7, 7, 1);
    opq[0] = '{1};
    opq[1] = '{2};
    req_len = {4'd1, 4'd1};
    req = 2'b11;
    run_until(4, 60, "B2");
    chk_res("B_next_r0", 2, 1, 1, 0);
    chk_res("B_next_r1", 3, 2, 2, 1);

    // C: r1 with stalls while r0 holds op_valid without a grant
    clear_logs();
    stall_pct[1] = 67;
    opq[1] = '{15, 15, 15, 15};
    opq[0] = '{9};
    req_len[LENW +: LENW] = 4'd4;
    req[1] = 1'b1;
    run_until(1, 400, "C");
    chk_res("C", 0, 60, 60, 1);
    opq[0].delete();
    stall_pct[1] = 0;

    // D: two full-length transactions of 15s; 6-bit instance wraps
    for (int n = 0; n < 2; n++) begin
      clear_logs();
      for (int j = 0; j < 15; j++) opq[0].push_back(15);
      req_len[0 +: LENW] = 4'd15;
      req[0] = 1'b1;
      run_until(1, 100, "D");
      chk_res("D", 0, 225, 33, 0);
    end

    // E: zero-length request goes straight through CLR to DONE
    clear_logs();
    req_len[0 +: LENW] = 4'd0;
    req[0] = 1'b1;
    t0 = cyc;
    run_until(1, 40, "E");
    chk_res("E", 0, 0, 0, 0);
    chk("E_res_cycle", (act_log.size() > 0) ? act_log[0].cyc : -1, t0 + 2);

    // F: reset after two of four operands, then a fresh transaction
    clear_logs();
    opq[0] = '{3, 3, 3, 3};
    req_len[0 +: LENW] = 4'd4;
    req[0] = 1'b1;
    k = 0;
    while (opq[0].size() > 2 && k < 40) begin
      step();
      k++;
    end
    chk("F_two_ops_taken", opq[0].size(), 2);
    do_reset(2);
    chk("F_no_result", act_log.size(), 0);
    opq[0] = '{1, 1};
    req_len[0 +: LENW] = 4'd2;
    req[0] = 1'b1;
    run_until(1, 40, "F");
    chk_res("F_after_reset", 0, 2, 2, 0);

    // Randomized traffic with occasional resets
    clear_logs();
    rand_mode = 1'b1;
    for (int ep = 0; ep < 15; ep++) begin
      for (int i = 0; i < NREQ; i++) stall_pct[i] = int'($urandom_range(0, 60));
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
        else step();
      end
    end
    rand_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) stall_pct[i] = 0;
    repeat (60) step();
    chk("rand_results_seen", int'(act_log.size() > 20), 1);
    chk("rand_result_count", act_log.size(), mdl_log.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
